// File: rtl/starter_pkg.sv
// Shared types and constants for the starter-choice menu and its downstream ID stage.
// Latency: none (definitions only).
// Backpressure: not applicable.
package starter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BROWSE  = 3'd1,
        CONFIRM = 3'd2,
        COMMIT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_BKSP  = 8'h2A;

    // Starter code meaning "no selection"; the ID-assignment stage ignores it.
    localparam logic [1:0] STARTER_NONE = 2'b11;
    localparam logic [1:0] CURSOR_MAX   = 2'd2;

    // Cursor step left, wrapping 0 -> 2.
    function automatic logic [1:0] cursor_left(input logic [1:0] cur);
        return (cur == 2'd0) ? CURSOR_MAX : cur - 2'd1;
    endfunction

    // Cursor step right, wrapping 2 -> 0.
    function automatic logic [1:0] cursor_right(input logic [1:0] cur);
        return (cur >= CURSOR_MAX) ? 2'd0 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/starter_menu_fsm_key_edge_detect.sv
// Turns a level keycode into a single-cycle press event (new non-zero code).
// Latency: combinational event from current keycode vs. previous-cycle keycode.
// Backpressure: none; every event is offered for exactly one cycle.
module key_edge_detect
    import starter_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       key_event,
    output logic [7:0] key_code
);

    logic [7:0] prev_key;

    // Remember last cycle's keycode so a held key only fires once.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prev_key <= KEY_NONE;
        end else begin
            prev_key <= keycode;
        end
    end

    assign key_event = (keycode != KEY_NONE) && (keycode != prev_key);
    assign key_code  = keycode;

endmodule

// File: rtl/starter_menu_fsm.sv
// Keyboard starter menu: cursor browse, yes/no confirm, one-cycle commit strobe.
// Latency: key event at edge N shows on outputs after edge N; all outputs registered.
// Backpressure: none; commit strobe is fire-and-forget, downstream must latch it.
module starter_menu_fsm
    import starter_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       menu_start,
    input  logic [7:0] keycode,
    output logic [1:0] starter_sel,
    output logic       sel_enable,
    output logic [1:0] cursor,
    output logic       confirm_active,
    output logic       blink,
    output logic       done
);

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic       key_event;
    logic [7:0] key_code;

    state_t     state, state_nxt;
    logic [1:0] cursor_nxt;
    logic [7:0] blink_cnt, blink_cnt_nxt;
    logic       blink_phase, blink_phase_nxt;
    logic       blink_nxt;

    key_edge_detect u_key (
        .Clk       (Clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .key_event (key_event),
        .key_code  (key_code)
    );

    // Next state, cursor and blink counter; outputs are derived from the next state
    // so that the registered outputs line up with the registered state.
    always_comb begin
        state_nxt       = state;
        cursor_nxt      = cursor;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;

        case (state)
            IDLE: begin
                if (menu_start) begin
                    state_nxt       = BROWSE;
                    cursor_nxt      = 2'd0;
                    blink_cnt_nxt   = 8'd0;
                    blink_phase_nxt = 1'b0;
                end
            end
            BROWSE: begin
                if (!menu_start) begin
                    state_nxt = IDLE;
                end else if (key_event) begin
                    case (key_code)
                        KEY_A:     cursor_nxt = cursor_left(cursor);
                        KEY_D:     cursor_nxt = cursor_right(cursor);
                        KEY_ENTER: state_nxt  = CONFIRM;
                        default:   ;
                    endcase
                end
            end
            CONFIRM: begin
                if (!menu_start) begin
                    state_nxt = IDLE;
                end else if (key_event) begin
                    if (key_code == KEY_ENTER) begin
                        state_nxt = COMMIT;
                    end else if (key_code == KEY_BKSP) begin
                        state_nxt = BROWSE;
                    end
                end
            end
            COMMIT:  state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase

        // Blink only advances while staying in BROWSE; a state change wins over a tick.
        if (state == BROWSE && state_nxt == BROWSE && frame_tick) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_cnt_nxt   = 8'd0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + 8'd1;
            end
        end

        blink_nxt = (state_nxt == CONFIRM) || ((state_nxt == BROWSE) && blink_phase_nxt);
    end

    // State and output registers; reset drops any commit in flight.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state          <= IDLE;
            cursor         <= 2'd0;
            blink_cnt      <= 8'd0;
            blink_phase    <= 1'b0;
            blink          <= 1'b0;
            starter_sel    <= STARTER_NONE;
            sel_enable     <= 1'b0;
            confirm_active <= 1'b0;
            done           <= 1'b0;
        end else begin
            state          <= state_nxt;
            cursor         <= cursor_nxt;
            blink_cnt      <= blink_cnt_nxt;
            blink_phase    <= blink_phase_nxt;
            blink          <= blink_nxt;
            starter_sel    <= (state_nxt == COMMIT) ? cursor_nxt : STARTER_NONE;
            sel_enable     <= (state_nxt == COMMIT);
            confirm_active <= (state_nxt == CONFIRM);
            done           <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_starter_menu_fsm.sv
// Self-checking bench for starter_menu_fsm: per-scenario tasks plus a strobe scoreboard.
// Latency: checks sampled 1 time unit after each rising edge; monitor on falling edge.
// Backpressure: none exercised; every commit strobe is matched against the scoreboard.
module tb_starter_menu_fsm;
    import starter_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       menu_start = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [1:0] starter_sel;
    logic       sel_enable;
    logic [1:0] cursor;
    logic       confirm_active;
    logic       blink;
    logic       done;

    int total = 0;
    int bad = 0;
    bit mon_on = 1'b0;
    logic [1:0] sb[$];
    logic [1:0] exp_cur;

    starter_menu_fsm #(.BLINK_FRAMES(3)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_tick     (frame_tick),
        .menu_start     (menu_start),
        .keycode        (keycode),
        .starter_sel    (starter_sel),
        .sel_enable     (sel_enable),
        .cursor         (cursor),
        .confirm_active (confirm_active),
        .blink          (blink),
        .done           (done)
    );

    always #5 Clk = ~Clk;

    // Scoreboard: every strobe must match a pushed expectation; otherwise code must be NONE.
    always @(negedge Clk) begin
        if (mon_on) begin
            total++;
            if (sel_enable === 1'b1) begin
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected: got sel_enable=1 starter_sel=%0d want no strobe", starter_sel);
                end else begin
                    logic [1:0] e;
                    e = sb.pop_front();
                    if (starter_sel !== e) begin
                        bad++;
                        $display("FAIL strobe_code: got %0d want %0d", starter_sel, e);
                    end
                end
            end else if (starter_sel !== STARTER_NONE || sel_enable !== 1'b0) begin
                bad++;
                $display("FAIL idle_code: got starter_sel=%0d sel_enable=%b want 3/0", starter_sel, sel_enable);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        keycode = 8'h00;
        step();
    endtask

    task automatic do_reset();
        Reset = 1'b0; menu_start = 1'b0; keycode = 8'h00; frame_tick = 1'b0;
        step();
        Reset = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        step(2);
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL rst_cursor: got %0d want 0", cursor); end
        total++; if (starter_sel !== 2'b11) begin bad++; $display("FAIL rst_sel: got %0d want 3", starter_sel); end
        total++; if ({sel_enable, confirm_active, blink, done} !== 4'b0000) begin bad++;
            $display("FAIL rst_flags: got %b want 0000", {sel_enable, confirm_active, blink, done}); end
        Reset = 1'b1; mon_on = 1'b1; menu_start = 1'b1;
        step();
        press(KEY_D); press(KEY_D);
        total++; if (cursor !== 2'd2) begin bad++; $display("FAIL pre_rst_cursor: got %0d want 2", cursor); end
        Reset = 1'b0;
        step();
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL midrst_cursor: got %0d want 0", cursor); end
        total++; if (blink !== 1'b0 || starter_sel !== 2'b11) begin bad++;
            $display("FAIL midrst_out: got blink=%b sel=%0d want 0/3", blink, starter_sel); end
        Reset = 1'b1; menu_start = 1'b0;
        press(KEY_D);
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL idle_ignores_key: got %0d want 0", cursor); end
    endtask

    task automatic test_cursor_commit();
        do_reset(); menu_start = 1'b1; step();
        exp_cur = 2'd0;
        for (int i = 0; i < 3; i++) begin
            press(KEY_D);
            exp_cur = (exp_cur == 2'd2) ? 2'd0 : exp_cur + 2'd1;
            total++; if (cursor !== exp_cur) begin bad++; $display("FAIL right_%0d: got %0d want %0d", i, cursor, exp_cur); end
        end
        keycode = KEY_D; step(20); keycode = 8'h00; step();
        exp_cur = 2'd1;
        total++; if (cursor !== exp_cur) begin bad++; $display("FAIL hold_d: got %0d want %0d", cursor, exp_cur); end
        for (int i = 0; i < 2; i++) begin
            press(KEY_A);
            exp_cur = (exp_cur == 2'd0) ? 2'd2 : exp_cur - 2'd1;
            total++; if (cursor !== exp_cur) begin bad++; $display("FAIL left_%0d: got %0d want %0d", i, cursor, exp_cur); end
        end
        press(KEY_ENTER);
        total++; if (confirm_active !== 1'b1) begin bad++; $display("FAIL enter_confirm: got %b want 1", confirm_active); end
        keycode = KEY_ENTER; sb.push_back(2'b10);
        step();
        total++; if (sel_enable !== 1'b1 || starter_sel !== 2'b10) begin bad++;
            $display("FAIL commit_strobe: got en=%b sel=%0d want 1/2", sel_enable, starter_sel); end
        keycode = 8'h00;
        step();
        total++; if (sel_enable !== 1'b0 || done !== 1'b1 || starter_sel !== 2'b11) begin bad++;
            $display("FAIL after_commit: got en=%b done=%b sel=%0d want 0/1/3", sel_enable, done, starter_sel); end
    endtask

    task automatic test_confirm_back();
        do_reset(); menu_start = 1'b1; step();
        press(KEY_D); press(KEY_ENTER); press(KEY_D);
        total++; if (cursor !== 2'd1 || confirm_active !== 1'b1) begin bad++;
            $display("FAIL confirm_frozen: got cur=%0d conf=%b want 1/1", cursor, confirm_active); end
        press(KEY_BKSP);
        total++; if (cursor !== 2'd1 || confirm_active !== 1'b0) begin bad++;
            $display("FAIL back: got cur=%0d conf=%b want 1/0", cursor, confirm_active); end
        press(KEY_ENTER);
        keycode = KEY_ENTER; sb.push_back(2'b01);
        step();
        total++; if (sel_enable !== 1'b1 || starter_sel !== 2'b01) begin bad++;
            $display("FAIL commit_1: got en=%b sel=%0d want 1/1", sel_enable, starter_sel); end
        keycode = 8'h00; step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_1: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        do_reset(); menu_start = 1'b1; step();
        keycode = KEY_D; step();
        total++; if (cursor !== 2'd1) begin bad++; $display("FAIL b2b_d: got %0d want 1", cursor); end
        keycode = KEY_A; step();
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL b2b_a: got %0d want 0", cursor); end
        keycode = 8'h05; step();
        total++; if (cursor !== 2'd0) begin bad++; $display("FAIL b2b_other: got %0d want 0", cursor); end
        keycode = KEY_A; step();
        total++; if (cursor !== 2'd2) begin bad++; $display("FAIL b2b_wrap: got %0d want 2", cursor); end
        keycode = 8'h00; step();
    endtask

    task automatic test_blink_abort();
        int toggles;
        logic last;
        do_reset(); menu_start = 1'b1; step();
        total++; if (blink !== 1'b0) begin bad++; $display("FAIL blink_start: got %b want 0", blink); end
        toggles = 0; last = blink;
        for (int i = 0; i < 9; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
            if (blink !== last) toggles++;
            last = blink;
        end
        total++; if (toggles != 3 || blink !== 1'b1) begin bad++;
            $display("FAIL blink_toggles: got %0d/%b want 3/1", toggles, blink); end
        press(KEY_ENTER);
        frame_tick = 1'b1; step(); frame_tick = 1'b0; step(3);
        total++; if (blink !== 1'b1) begin bad++; $display("FAIL blink_confirm: got %b want 1", blink); end
        press(KEY_BKSP);
        frame_tick = 1'b1; keycode = KEY_ENTER; step();
        frame_tick = 1'b0; keycode = 8'h00; step();
        total++; if (blink !== 1'b1 || confirm_active !== 1'b1) begin bad++;
            $display("FAIL tick_with_enter: got blink=%b conf=%b want 1/1", blink, confirm_active); end
        menu_start = 1'b0; step();
        total++; if (confirm_active !== 1'b0 || blink !== 1'b0 || sel_enable !== 1'b0) begin bad++;
            $display("FAIL abort: got conf=%b blink=%b en=%b want 0/0/0", confirm_active, blink, sel_enable); end
        press(KEY_ENTER);
        menu_start = 1'b1; step();
        press(KEY_D);
        menu_start = 1'b0; step(); menu_start = 1'b1; step();
        total++; if (cursor !== 2'd0 || done !== 1'b0) begin bad++;
            $display("FAIL reentry: got cur=%0d done=%b want 0/0", cursor, done); end
    endtask

    task automatic test_done_reset();
        do_reset(); menu_start = 1'b1; step();
        press(KEY_ENTER);
        keycode = KEY_ENTER; Reset = 1'b0; step();
        total++; if (sel_enable !== 1'b0 || confirm_active !== 1'b0 || starter_sel !== 2'b11) begin bad++;
            $display("FAIL rst_in_commit: got en=%b conf=%b sel=%0d want 0/0/3", sel_enable, confirm_active, starter_sel); end
        Reset = 1'b1; keycode = 8'h00; step();
        press(KEY_ENTER);
        keycode = KEY_ENTER; sb.push_back(2'b00); step();
        keycode = 8'h00; step();
        menu_start = 1'b0; step(); menu_start = 1'b1; step();
        press(KEY_ENTER); press(KEY_D); press(KEY_ENTER);
        total++; if (done !== 1'b1 || cursor !== 2'd0 || sel_enable !== 1'b0) begin bad++;
            $display("FAIL done_absorb: got done=%b cur=%0d en=%b want 1/0/0", done, cursor, sel_enable); end
    endtask

    initial begin
        test_reset();
        test_cursor_commit();
        test_confirm_back();
        test_back_to_back();
        test_blink_abort();
        test_done_reset();
        step(3);
        total++; if (sb.size() != 0) begin bad++; $display("FAIL strobes_missing: got %0d pending want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/starter_menu_fsm.md
# starter_menu_fsm

Keyboard-driven starter-choice menu that sits directly upstream of the starter ID-assignment stage. Walks a cursor over the three starters and asks for a yes/no confirmation. On commit it drives the `starter_sel` / `sel_enable` pair for exactly one cycle, so the downstream stage latches a new Pokémon ID once. It also exports cursor position, menu-phase flags and a cursor blink bit to the menu sprite renderer.

## Interface
Parameters:
- `BLINK_FRAMES`, default 15: frame ticks per cursor blink half-period; legal range 1..255.

Ports:
- `Clk`  in  1  system clock; everything is on its rising edge.
- `Reset`  in  1  synchronous, active-low reset, sampled on rising edge of `Clk`.
- `frame_tick`  in  1  one-cycle pulse per video frame (vsync-derived).
- `menu_start`  in  1  level; menu runs only while high.
- `keycode`  in  8  current USB HID keycode; 0x00 means no key.
- `starter_sel`  out  2  starter code to downstream stage; 2'b11 whenever not committing.
- `sel_enable`  out  1  one-cycle commit strobe to downstream stage.
- `cursor`  out  2  highlighted starter, 0..2.
- `confirm_active`  out  1  high while the yes/no prompt is shown.
- `blink`  out  1  cursor visibility for the renderer.
- `done`  out  1  high once a starter has been committed.

## Operation
- Key event: registered `prev_key`; event when `keycode != 0` and `keycode != prev_key`. A held key produces one event. Only one event is handled per cycle.
- Keycodes: A = 0x04 (left), D = 0x07 (right), Enter = 0x28 (accept), Backspace = 0x2A (back). All other codes are ignored.
- States:
  - IDLE → BROWSE when `menu_start` is 1. On entry to BROWSE, `cursor` = 0 and the blink counter clears.
  - BROWSE: left moves `cursor` down by 1, wrapping 0→2. Right moves it up by 1, wrapping 2→0. Enter → CONFIRM.
  - CONFIRM: `confirm_active` = 1 and `cursor` is frozen. Enter → COMMIT. Backspace → BROWSE with `cursor` kept. Left/right are ignored.
  - COMMIT: lasts one cycle. `sel_enable` = 1 and `starter_sel` = `cursor`. Then unconditional → DONE.
  - DONE: `done` = 1. Absorbing until reset. All keys are ignored.
- `menu_start` falling in BROWSE or CONFIRM → IDLE. COMMIT still completes, and DONE ignores `menu_start`.
- Blink:
  - In BROWSE, the 8-bit counter increments on `frame_tick`. When it reaches `BLINK_FRAMES - 1` it wraps to 0 and `blink` toggles.
  - In CONFIRM, `blink` is forced to 1 and the counter holds.
  - In IDLE and DONE, `blink` = 0.
- `cursor` is never 3. Any illegal state decodes to IDLE.

## Timing
- Reset values: state IDLE, `cursor` 0, `starter_sel` 2'b11, `sel_enable` 0, `confirm_active` 0, `blink` 0, `done` 0, `prev_key` 0x00, blink counter 0.
- All outputs are registered.
- A key event sampled at edge N is reflected in `cursor` / state outputs after edge N.
- Enter in CONFIRM at edge N: `sel_enable` is high during cycle N+1 only; `done` goes high from cycle N+2.
- Reset asserted in any state, including COMMIT, forces reset values at the next edge. A commit in progress is dropped and no strobe is issued.
- A `frame_tick` coinciding with a key event: both are processed in the same cycle. A state change wins: if the state leaves BROWSE, blink follows the new state's rule.

## Structure
- Package `starter_pkg`:
  - state enum (IDLE, BROWSE, CONFIRM, COMMIT, DONE);
  - keycode constants `KEY_A`, `KEY_D`, `KEY_ENTER`, `KEY_BKSP`;
  - starter code constant `STARTER_NONE` = 2'b11.
- The downstream ID-assignment stage shares `STARTER_NONE`.
- Sub-module `key_edge_detect`: `Clk`, `Reset`, `keycode` → `key_event`, `key_code`.
- The FSM, cursor logic and blink counter stay in the top module.

## Test plan
- Reset mid-BROWSE with `cursor` = 2 → next edge: `cursor` 0, state IDLE, `blink` 0, `starter_sel` 2'b11.
- Start menu, press D three times (each pressed and released) → `cursor` goes 1, 2, 0. Hold D for 20 cycles → exactly one increment.
- From `cursor` 0 press A → `cursor` 2. Enter → `confirm_active` 1. Enter → `sel_enable` high for exactly one cycle with `starter_sel` 2'b10. Then `done` 1 and `starter_sel` 2'b11.
- In CONFIRM with `cursor` 1, press D → `cursor` stays 1. Backspace → `confirm_active` 0 and `cursor` 1. Enter, Enter → single strobe with `starter_sel` 2'b01.
- `BLINK_FRAMES` = 3, 9 `frame_tick`s in BROWSE → `blink` toggles 3 times. Enter CONFIRM → `blink` 1 regardless.
- Drop `menu_start` in CONFIRM → IDLE, no strobe. In DONE, toggle `menu_start` and press Enter → no further `sel_enable`.
